// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
// Imported by the fetch unit and its instruction buffer.
package cpu_pkg;

  localparam int ADDR_W   = 18;
  localparam int RESET_PC = 0;
  localparam int PC_STEP  = 4;

  typedef enum logic {
    FS_HI = 1'b0,
    FS_LO = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction/PC holding register between fetch and decode.
// A flush beats a capture; a capture beats a consume.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int AW = cpu_pkg::ADDR_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          capture,
  input  logic          flush,
  input  logic          stall,
  input  logic [31:0]   data,
  input  logic [AW-1:0] pc,
  output logic          valid,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid    <= 1'b1;
      instr    <= data;
      instr_pc <= pc;
    end else if (!stall) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: two-phase 32-bit reads over a 16-bit path,
// yielding to the memory stage and absorbing branch redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int RESET_PC = cpu_pkg::RESET_PC,
  parameter int PC_STEP  = cpu_pkg::PC_STEP
) (
  input  logic              clock,
  input  logic              reset,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  input  logic [31:0]       mc_if_data,
  input  logic              mem_mc_en,
  output logic              if_mem_grant,
  input  logic              ex_if_branch_en,
  input  logic [ADDR_W-1:0] ex_if_branch_addr,
  input  logic              id_if_stall,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc
);

  fetch_state_t      state;
  logic              mc_step;
  logic [ADDR_W-1:0] pc;
  logic              buf_free;
  logic              start;
  logic              capture;

  assign buf_free = !if_id_valid || !id_if_stall;

  // A branch in HI delays issue one cycle so the pair starts at the target
  assign start = (state == FS_HI) && !mc_step && !mem_mc_en
              && buf_free && !ex_if_branch_en;

  assign if_mc_en     = !reset && ((state == FS_LO) || start);
  assign if_mc_addr   = pc;
  assign if_mem_grant = !mc_step;
  assign capture      = (state == FS_LO) && !ex_if_branch_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= FS_HI;
      mc_step <= 1'b0;
      pc      <= ADDR_W'(RESET_PC);
    end else begin
      if (if_mc_en || mem_mc_en)
        mc_step <= ~mc_step;
      if (ex_if_branch_en)
        pc <= ex_if_branch_addr;
      else if (state == FS_LO)
        pc <= pc + ADDR_W'(PC_STEP);
      unique case (state)
        FS_HI: if (start) state <= FS_LO;
        FS_LO: state <= FS_HI;
      endcase
    end
  end

  fetch_buffer #(
    .AW(ADDR_W)
  ) u_buf (
    .clock    (clock),
    .reset    (reset),
    .capture  (capture),
    .flush    (ex_if_branch_en),
    .stall    (id_if_stall),
    .data     (mc_if_data),
    .pc       (pc),
    .valid    (if_id_valid),
    .instr    (if_id_instr),
    .instr_pc (if_id_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small two-phase controller/RAM model.
// Each task resets the DUT and checks one scenario cycle by cycle.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_mc_en;
  logic [17:0] if_mc_addr;
  logic [31:0] mc_if_data;
  logic        mem_mc_en;
  logic        if_mem_grant;
  logic        ex_if_branch_en;
  logic [17:0] ex_if_branch_addr;
  logic        id_if_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [17:0] if_id_pc;

  int checks = 0;
  int failures = 0;
  logic tb_step;

  fetch_unit dut (
    .clock             (clock),
    .reset             (reset),
    .if_mc_en          (if_mc_en),
    .if_mc_addr        (if_mc_addr),
    .mc_if_data        (mc_if_data),
    .mem_mc_en         (mem_mc_en),
    .if_mem_grant      (if_mem_grant),
    .ex_if_branch_en   (ex_if_branch_en),
    .ex_if_branch_addr (ex_if_branch_addr),
    .id_if_stall       (id_if_stall),
    .if_id_valid       (if_id_valid),
    .if_id_instr       (if_id_instr),
    .if_id_pc          (if_id_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ram(input logic [17:0] a);
    case (a)
      18'h00000: ram = 32'h11112222;
      18'h00004: ram = 32'h33334444;
      18'h00008: ram = 32'h55556666;
      18'h00100: ram = 32'hCAFE0100;
      18'h3FFFC: ram = 32'hDEADBEEF;
      default:   ram = {14'h0, a};
    endcase
  endfunction

  // Controller model: word data only appears in its phase 1
  always @(posedge clock) begin
    if (reset) tb_step <= 1'b0;
    else if (if_mc_en || mem_mc_en) tb_step <= ~tb_step;
  end
  assign mc_if_data = tb_step ? ram(if_mc_addr) : 32'hBAD0BAD0;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_mc_en = 1'b0;
    ex_if_branch_en = 1'b0;
    ex_if_branch_addr = '0;
    id_if_stall = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_mc_en = 1'b0;
    ex_if_branch_en = 1'b0;
    ex_if_branch_addr = '0;
    id_if_stall = 1'b0;
    cyc(); cyc(); cyc();
    checks++;
    if (if_id_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got=%0h exp=0", if_id_valid);
    end
    checks++;
    if (if_id_instr !== 32'h0) begin
      failures++; $display("FAIL rst_instr got=%0h exp=0", if_id_instr);
    end
    checks++;
    if (if_id_pc !== 18'h0) begin
      failures++; $display("FAIL rst_pc got=%0h exp=0", if_id_pc);
    end
    checks++;
    if (if_mc_en !== 1'b0) begin
      failures++; $display("FAIL rst_en got=%0h exp=0", if_mc_en);
    end
    checks++;
    if (if_mem_grant !== 1'b1) begin
      failures++; $display("FAIL rst_grant got=%0h exp=1", if_mem_grant);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    #1;
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h0) begin
      failures++;
      $display("FAIL f_issue0 got=%0h/%0h exp=1/0", if_mc_en, if_mc_addr);
    end
    cyc();
    checks++;
    if (if_mc_en !== 1'b1 || if_mem_grant !== 1'b0 || if_id_valid !== 1'b0) begin
      failures++;
      $display("FAIL f_lo got=%0h/%0h/%0h exp=1/0/0", if_mc_en, if_mem_grant, if_id_valid);
    end
    cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h11112222 || if_id_pc !== 18'h0) begin
      failures++;
      $display("FAIL f_cap0 got=%0h/%0h/%0h exp=1/11112222/0", if_id_valid, if_id_instr, if_id_pc);
    end
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h4) begin
      failures++;
      $display("FAIL f_issue4 got=%0h/%0h exp=1/4", if_mc_en, if_mc_addr);
    end
    cyc();
    checks++;
    if (if_id_valid !== 1'b0) begin
      failures++; $display("FAIL f_consume got=%0h exp=0", if_id_valid);
    end
    cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h33334444 || if_id_pc !== 18'h4) begin
      failures++;
      $display("FAIL f_cap4 got=%0h/%0h/%0h exp=1/33334444/4", if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    id_if_stall = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h11112222
          || if_id_pc !== 18'h0 || if_mc_en !== 1'b0) begin
        failures++;
        $display("FAIL s_hold%0d got=%0h/%0h/%0h/%0h exp=1/11112222/0/0",
                 i, if_id_valid, if_id_instr, if_id_pc, if_mc_en);
      end
      cyc();
    end
    id_if_stall = 1'b0;
    #1;
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h4) begin
      failures++;
      $display("FAIL s_resume got=%0h/%0h exp=1/4", if_mc_en, if_mc_addr);
    end
    cyc(); cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h33334444 || if_id_pc !== 18'h4) begin
      failures++;
      $display("FAIL s_cap4 got=%0h/%0h/%0h exp=1/33334444/4", if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_mem();
    do_reset();
    checks++;
    if (if_mem_grant !== 1'b1) begin
      failures++; $display("FAIL m_grant0 got=%0h exp=1", if_mem_grant);
    end
    mem_mc_en = 1'b1;
    #1;
    checks++;
    if (if_mc_en !== 1'b0) begin
      failures++; $display("FAIL m_en0 got=%0h exp=0", if_mc_en);
    end
    cyc();
    #1;
    checks++;
    if (if_mc_en !== 1'b0 || if_mem_grant !== 1'b0) begin
      failures++;
      $display("FAIL m_cyc1 got=%0h/%0h exp=0/0", if_mc_en, if_mem_grant);
    end
    cyc();
    mem_mc_en = 1'b0;
    #1;
    checks++;
    if (if_mem_grant !== 1'b1 || if_mc_en !== 1'b1 || if_mc_addr !== 18'h0) begin
      failures++;
      $display("FAIL m_after got=%0h/%0h/%0h exp=1/1/0", if_mem_grant, if_mc_en, if_mc_addr);
    end
    cyc(); cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h11112222 || if_id_pc !== 18'h0) begin
      failures++;
      $display("FAIL m_cap got=%0h/%0h/%0h exp=1/11112222/0", if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_branch_lo();
    do_reset();
    cyc();
    ex_if_branch_en = 1'b1;
    ex_if_branch_addr = 18'h00100;
    cyc();
    ex_if_branch_en = 1'b0;
    #1;
    checks++;
    if (if_id_valid !== 1'b0) begin
      failures++; $display("FAIL b_drop got=%0h exp=0", if_id_valid);
    end
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h00100) begin
      failures++;
      $display("FAIL b_issue got=%0h/%0h exp=1/100", if_mc_en, if_mc_addr);
    end
    cyc(); cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hCAFE0100 || if_id_pc !== 18'h00100) begin
      failures++;
      $display("FAIL b_cap got=%0h/%0h/%0h exp=1/cafe0100/100", if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_branch_consume();
    do_reset();
    cyc(); cyc();
    ex_if_branch_en = 1'b1;
    ex_if_branch_addr = 18'h00008;
    #1;
    checks++;
    if (if_id_valid !== 1'b1 || if_mc_en !== 1'b0) begin
      failures++;
      $display("FAIL bc_nodup got=%0h/%0h exp=1/0", if_id_valid, if_mc_en);
    end
    cyc();
    ex_if_branch_en = 1'b0;
    #1;
    checks++;
    if (if_id_valid !== 1'b0 || if_mc_en !== 1'b1 || if_mc_addr !== 18'h8) begin
      failures++;
      $display("FAIL bc_issue got=%0h/%0h/%0h exp=0/1/8", if_id_valid, if_mc_en, if_mc_addr);
    end
    cyc(); cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'h55556666 || if_id_pc !== 18'h8) begin
      failures++;
      $display("FAIL bc_cap got=%0h/%0h/%0h exp=1/55556666/8", if_id_valid, if_id_instr, if_id_pc);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    ex_if_branch_en = 1'b1;
    ex_if_branch_addr = 18'h3FFFC;
    #1;
    checks++;
    if (if_mc_en !== 1'b0) begin
      failures++; $display("FAIL w_hold got=%0h exp=0", if_mc_en);
    end
    cyc();
    ex_if_branch_en = 1'b0;
    #1;
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h3FFFC) begin
      failures++;
      $display("FAIL w_issue got=%0h/%0h exp=1/3fffc", if_mc_en, if_mc_addr);
    end
    cyc(); cyc();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_instr !== 32'hDEADBEEF || if_id_pc !== 18'h3FFFC) begin
      failures++;
      $display("FAIL w_cap got=%0h/%0h/%0h exp=1/deadbeef/3fffc", if_id_valid, if_id_instr, if_id_pc);
    end
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h0) begin
      failures++;
      $display("FAIL w_wrap got=%0h/%0h exp=1/0", if_mc_en, if_mc_addr);
    end
    cyc();
    checks++;
    if (if_mem_grant !== 1'b0 || if_mc_en !== 1'b1) begin
      failures++;
      $display("FAIL w_lo got=%0h/%0h exp=0/1", if_mem_grant, if_mc_en);
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_mem_grant !== 1'b1
        || if_mc_en !== 1'b0) begin
      failures++;
      $display("FAIL w_rst got=%0h/%0h/%0h/%0h exp=0/0/1/0",
               if_id_valid, if_id_instr, if_mem_grant, if_mc_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h0) begin
      failures++;
      $display("FAIL w_restart got=%0h/%0h exp=1/0", if_mc_en, if_mc_addr);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_mem();
    test_branch_lo();
    test_branch_consume();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
